// File: rtl/mix_columns_pkg.sv
// Shared GF(2^8) arithmetic for the AES MixColumns datapath.
// The inverse multipliers are built only when MIX_COLUMNS_INV_EN is defined.
package mix_columns_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        logic [7:0] r;
        if (x[7]) begin
            r = {x[6:0], 1'b0} ^ AES_POLY;
        end else begin
            r = {x[6:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse coefficients decomposed into x*8, x*4 and x*2 terms
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction
`endif

endpackage

// File: rtl/mix_columns_col.sv
// Combinational MixColumns of one 32-bit column (byte 0 in bits [31:24]).
// The inv select exists only when MIX_COLUMNS_INV_EN is defined.
module mix_column
    import mix_columns_pkg::*;
(
    input  logic [31:0] col_in,
`ifdef MIX_COLUMNS_INV_EN
    input  logic        inv,
`endif
    output logic [31:0] col_out
);

    logic [7:0] a0_s, a1_s, a2_s, a3_s;

    assign a0_s = col_in[31:24];
    assign a1_s = col_in[23:16];
    assign a2_s = col_in[15:8];
    assign a3_s = col_in[7:0];

    // Matrix multiply of the column; each output row is the previous one rotated right
    always_comb begin
        col_out = 32'h0000_0000;
`ifdef MIX_COLUMNS_INV_EN
        if (inv) begin
            col_out[31:24] = gf_mul0e(a0_s) ^ gf_mul0b(a1_s) ^ gf_mul0d(a2_s) ^ gf_mul9(a3_s);
            col_out[23:16] = gf_mul9(a0_s)  ^ gf_mul0e(a1_s) ^ gf_mul0b(a2_s) ^ gf_mul0d(a3_s);
            col_out[15:8]  = gf_mul0d(a0_s) ^ gf_mul9(a1_s)  ^ gf_mul0e(a2_s) ^ gf_mul0b(a3_s);
            col_out[7:0]   = gf_mul0b(a0_s) ^ gf_mul0d(a1_s) ^ gf_mul9(a2_s)  ^ gf_mul0e(a3_s);
        end else begin
            col_out[31:24] = gf_mul2(a0_s) ^ gf_mul3(a1_s) ^ a2_s ^ a3_s;
            col_out[23:16] = a0_s ^ gf_mul2(a1_s) ^ gf_mul3(a2_s) ^ a3_s;
            col_out[15:8]  = a0_s ^ a1_s ^ gf_mul2(a2_s) ^ gf_mul3(a3_s);
            col_out[7:0]   = gf_mul3(a0_s) ^ a1_s ^ a2_s ^ gf_mul2(a3_s);
        end
`else
        col_out[31:24] = gf_mul2(a0_s) ^ gf_mul3(a1_s) ^ a2_s ^ a3_s;
        col_out[23:16] = a0_s ^ gf_mul2(a1_s) ^ gf_mul3(a2_s) ^ a3_s;
        col_out[15:8]  = a0_s ^ a1_s ^ gf_mul2(a2_s) ^ gf_mul3(a3_s);
        col_out[7:0]   = gf_mul3(a0_s) ^ a1_s ^ a2_s ^ gf_mul2(a3_s);
`endif
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns over a 128-bit column-major state with a single output register.
// Defining MIX_COLUMNS_INV_EN adds the inv port selecting InvMixColumns.
module mix_columns
    import mix_columns_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    logic [127:0] mix_s;
    logic [127:0] state_r;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_column u_col (
            .col_in  (state_in[127-32*c -: 32]),
`ifdef MIX_COLUMNS_INV_EN
            .inv     (inv),
`endif
            .col_out (mix_s[127-32*c -: 32])
        );
    end

    // Output register: reloads every cycle, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 128'h0;
        end else begin
            state_r <= mix_s;
        end
    end

    assign state_out = state_r;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: scoreboard queue fed at drive time,
// popped one cycle later; inverse tests run when MIX_COLUMNS_INV_EN is defined.
module tb_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         inv;
    logic [127:0] state_in;
    logic [127:0] state_out;

    logic [127:0] sb_q[$];
    int           n_vec;
    int           n_err;

    localparam logic [127:0] V_FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V_FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V_KNOWN_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_KNOWN_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_MORE_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V_MORE_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MIX_COLUMNS_INV_EN
        .inv       (inv),
`endif
        .state_in  (state_in),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: generic shift-and-add multiply with polynomial reduction
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
        logic [7:0]   row0 [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r;
        r = 128'h0;
        if (iv) begin
            row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ m_mul(row0[(k - rr + 4) % 4], a[k]);
                r[127 - 32*c - 8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic [127:0] v, input logic iv, input logic [127:0] exp);
        @(negedge clk);
        state_in = v;
        inv      = iv;
        sb_q.push_back(exp);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        inv      = 1'b0;
        state_in = rand128();
        #1;
        n_vec++;
        if (state_out !== 128'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h, want 0", state_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            state_in = rand128();
            @(posedge clk); #1;
            n_vec++;
            if (state_out !== 128'h0) begin
                n_err++;
                $display("FAIL reset_hold: got %h, want 0", state_out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        state_in = V_FIPS_IN;
        @(posedge clk); #1;
        n_vec++;
        if (state_out !== V_FIPS_OUT) begin
            n_err++;
            $display("FAIL reset_first_edge: got %h, want %h", state_out, V_FIPS_OUT);
        end
        // Assert reset while clk is high: output must clear with no edge
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (state_out !== 128'h0) begin
            n_err++;
            $display("FAIL reset_midcycle: got %h, want 0", state_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [127:0] exp;
        string nm [3];
        logic [127:0] vin [3];
        logic [127:0] vout [3];
        nm[0] = "fips";  vin[0] = V_FIPS_IN;  vout[0] = V_FIPS_OUT;
        nm[1] = "known"; vin[1] = V_KNOWN_IN; vout[1] = V_KNOWN_OUT;
        nm[2] = "more";  vin[2] = V_MORE_IN;  vout[2] = V_MORE_OUT;
        for (int i = 0; i < 3; i++) begin
            drive(vin[i], 1'b0, vout[i]);
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            exp = sb_q.pop_front();
            if (state_out !== exp) begin
                n_err++;
                $display("FAIL vec_%s: got %h, want %h", nm[i], state_out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin [3];
        logic [127:0] vout [3];
        logic [127:0] exp;
        vin[0] = V_FIPS_IN;  vout[0] = V_FIPS_OUT;
        vin[1] = V_KNOWN_IN; vout[1] = V_KNOWN_OUT;
        vin[2] = V_MORE_IN;  vout[2] = V_MORE_OUT;
        for (int i = 0; i < 3; i++) begin
            drive(vin[i], 1'b0, vout[i]);
            @(posedge clk); #1;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_%0d: scoreboard empty, got %h", i, state_out);
            end else begin
                exp = sb_q.pop_front();
                if (state_out !== exp) begin
                    n_err++;
                    $display("FAIL stream_%0d: got %h, want %h", i, state_out, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] v;
        logic [127:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = rand128();
            drive(v, 1'b0, model(v, 1'b0));
            @(posedge clk); #1;
            n_vec++;
            exp = sb_q.pop_front();
            if (state_out !== exp) begin
                n_err++;
                $display("FAIL random_%0d: in %h got %h, want %h", i, v, state_out, exp);
            end
        end
    endtask

    task automatic test_mid_stream_reset();
        drive(V_KNOWN_IN, 1'b0, V_KNOWN_OUT);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        sb_q.delete();
        n_vec++;
        if (state_out !== 128'h0) begin
            n_err++;
            $display("FAIL midstream_reset: got %h, want 0", state_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(V_MORE_IN, 1'b0, V_MORE_OUT);
        @(posedge clk); #1;
        n_vec++;
        if (state_out !== sb_q.pop_front()) begin
            n_err++;
            $display("FAIL midstream_recover: got %h, want %h", state_out, V_MORE_OUT);
        end
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inverse();
        logic [127:0] v;
        logic [127:0] exp;
        drive(V_FIPS_OUT, 1'b1, V_FIPS_IN);
        @(posedge clk); #1;
        n_vec++;
        exp = sb_q.pop_front();
        if (state_out !== exp) begin
            n_err++;
            $display("FAIL inv_fips: got %h, want %h", state_out, exp);
        end
        for (int i = 0; i < 6; i++) begin
            v = rand128();
            drive(v, i[0], model(v, i[0]));
            @(posedge clk); #1;
            n_vec++;
            exp = sb_q.pop_front();
            if (state_out !== exp) begin
                n_err++;
                $display("FAIL inv_mixed_%0d: got %h, want %h", i, state_out, exp);
            end
        end
        @(negedge clk);
        inv = 1'b0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_mid_stream_reset();
`ifdef MIX_COLUMNS_INV_EN
        test_inverse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mix_columns.md
MIX_COLUMNS -- requirements
Module: mix_columns

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 Port state_in SHALL be input 128: AES state, column-major; column c = bits [127-32c -: 32]; byte r of a column = bits [31-8r -: 8] within it, so bits [127:120] = s(0,0).
REQ-003 Port state_out SHALL be output 128: MixColumns result, same byte layout, registered.
REQ-004 With MIX_COLUMNS_INV_EN defined, port inv SHALL exist as input 1: 0 = forward MixColumns, 1 = InvMixColumns; without the macro the port SHALL be absent.

Function
REQ-005 Each 32-bit column (a0,a1,a2,a3) SHALL map independently to b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, over GF(2^8) mod 0x11B.
REQ-006 xtime(x) SHALL be (x<<1)[7:0] XOR (0x1B if x[7]); 3x = xtime(x)^x.
REQ-007 The transform SHALL be purely combinational, with state_out registered on the rising clk edge: latency exactly 1 cycle, throughput one state per cycle.
REQ-008 No handshake SHALL exist; state_out SHALL reload every cycle from the state_in value sampled at that edge.
REQ-009 Back-to-back differing inputs on consecutive cycles SHALL each produce their own result one cycle later, with no intermediate mixing.
REQ-010 X/undefined inputs are outside the block's responsibility; no input checking SHALL be performed.

Reset
REQ-011 rst_n low SHALL asynchronously force state_out to 128'h0, independent of clk.
REQ-012 While rst_n is low, state_out SHALL hold 0; the first edge after deassertion SHALL capture the transform of the current state_in.
REQ-013 Reset asserted mid-stream SHALL discard the pending result; no recovery sequence SHALL be required.

Configuration
REQ-014 Macro MIX_COLUMNS_INV_EN defined: with inv=1 each column SHALL use the inverse matrix rows (0e,0b,0d,09) rotated, with inv sampled in the same cycle as state_in and the same 1-cycle latency.
REQ-015 Macro MIX_COLUMNS_INV_EN undefined: the block SHALL be forward-only, with no inverse logic synthesized.

Structure
REQ-016 Package mix_columns_pkg SHALL hold the xtime/gf_mul2/gf_mul3 functions (plus gf_mul9/0b/0d/0e under the macro) and the constant AES_POLY = 8'h1B.
REQ-017 One combinational sub-module, mix_column (32-bit in, 32-bit out, optional inv), SHALL be instantiated four times; the top SHALL hold only the output register and reset.

Verification
REQ-018 Reset: rst_n=0 with state_in random -> state_out == 0 immediately, without waiting for a clock edge.
REQ-019 FIPS-197 vector: state_in=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> state_out=046681e5_e0cb199a_48f8d37a_2806264c one cycle later.
REQ-020 Known columns: state_in=db135345_f20a225c_01010101_c6c6c6c6 -> state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-021 Further columns: state_in=d4d4d4d5_2d26314c_00000000_ffffffff -> state_out=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
REQ-022 Streaming: apply the vectors of REQ-019, REQ-020 and REQ-021 on three consecutive edges -> outputs appear in order on the following three edges.
REQ-023 Inverse (MIX_COLUMNS_INV_EN defined, inv=1): state_in=046681e5_e0cb199a_48f8d37a_2806264c -> state_out=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
